// File: rtl/task_dispatch.sv
// task_dispatch: scans Ready task words, dispatches the highest priority (round-robin on ties)
// for a fixed slice, and forwards host op words onto the shared op bus. Define TASK_DISPATCH_STATS_EN for dispatch_count.
module task_dispatch #(
   parameter int N_TASKS      = 8,
   parameter int SLICE_CYCLES = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [8*N_TASKS-1:0] task_bus,
   input  logic [15:0]          host_op,
   input  logic                 host_valid,
   output logic                 host_ready,
   output logic [15:0]          op_out,
   output logic                 cur_valid,
   output logic [3:0]           cur_id,
`ifdef TASK_DISPATCH_STATS_EN
   output logic [15:0]          dispatch_count,
`endif
   output logic                 busy
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_HOST   = 3'd1;
   localparam logic [2:0] ST_SCAN   = 3'd2;
   localparam logic [2:0] ST_ISSUE  = 3'd3;
   localparam logic [2:0] ST_RUN    = 3'd4;
   localparam logic [2:0] ST_FINISH = 3'd5;

   localparam int           CW         = $clog2(SLICE_CYCLES + 1);
   localparam logic [CW-1:0] SLICE_LOAD = CW'(SLICE_CYCLES);
   localparam logic [4:0]   NT         = 5'(N_TASKS);
   localparam logic [3:0]   LAST_K     = 4'(N_TASKS - 1);

   logic [2:0]    state_q, state_d;
   logic [3:0]    start_q, start_d;
   logic [3:0]    scan_k_q, scan_k_d;
   logic          best_found_q, best_found_d;
   logic [3:0]    best_prio_q, best_prio_d;
   logic [3:0]    best_slot_q, best_slot_d;
   logic [3:0]    best_id_q, best_id_d;
   logic [CW-1:0] slice_q, slice_d;
   logic [15:0]   op_q, op_d;

   logic [4:0]    scan_sum;
   logic [3:0]    scan_slot;
   logic [7:0]    scan_word;
   logic [7:0]    run_word;
   logic          take;

   // Slot examined this scan cycle is (start + k) mod N_TASKS.
   always_comb begin
      scan_sum  = {1'b0, start_q} + {1'b0, scan_k_q};
      scan_slot = (scan_sum >= NT) ? 4'(scan_sum - NT) : scan_sum[3:0];
   end

   always_comb begin
      scan_word = 8'h00;
      run_word  = 8'h00;
      for (int j = 0; j < N_TASKS; j++) begin
         if (scan_slot == 4'(j)) scan_word = task_bus[8*j +: 8];
         if (best_slot_q == 4'(j)) run_word = task_bus[8*j +: 8];
      end
   end

   assign take = (scan_word[3:0] != 4'h0) && (scan_word[3:0] > best_prio_q);

   always_comb begin
      state_d      = state_q;
      start_d      = start_q;
      scan_k_d     = scan_k_q;
      best_found_d = best_found_q;
      best_prio_d  = best_prio_q;
      best_slot_d  = best_slot_q;
      best_id_d    = best_id_q;
      slice_d      = slice_q;
      op_d         = 16'h0000;
      case (state_q)
         ST_IDLE: begin
            if (host_valid) begin
               op_d    = host_op;
               state_d = ST_HOST;
            end else begin
               best_found_d = 1'b0;
               best_prio_d  = 4'h0;
               best_slot_d  = 4'h0;
               best_id_d    = 4'h0;
               scan_k_d     = 4'h0;
               state_d      = ST_SCAN;
            end
         end
         ST_HOST: state_d = ST_IDLE;
         ST_SCAN: begin
            if (take) begin
               best_found_d = 1'b1;
               best_prio_d  = scan_word[3:0];
               best_slot_d  = scan_slot;
               best_id_d    = scan_word[7:4];
            end
            // The last slot's verdict must reach the Execute word registered this cycle.
            if (scan_k_q == LAST_K) begin
               if (best_found_d) begin
                  op_d    = {4'h0, best_id_d, 4'h7, 4'h0};
                  state_d = ST_ISSUE;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               scan_k_d = scan_k_q + 4'd1;
            end
         end
         ST_ISSUE: begin
            slice_d = SLICE_LOAD;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if ((run_word == 8'h00) || (slice_q == CW'(1))) begin
               op_d    = {4'h0, best_id_q, 4'hF, 4'h0};
               slice_d = '0;
               state_d = ST_FINISH;
            end else begin
               slice_d = slice_q - CW'(1);
            end
         end
         ST_FINISH: begin
            start_d = (best_slot_q == LAST_K) ? 4'h0 : best_slot_q + 4'd1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= ST_IDLE;
         start_q      <= 4'h0;
         scan_k_q     <= 4'h0;
         best_found_q <= 1'b0;
         best_prio_q  <= 4'h0;
         best_slot_q  <= 4'h0;
         best_id_q    <= 4'h0;
         slice_q      <= '0;
         op_q         <= 16'h0000;
      end else begin
         state_q      <= state_d;
         start_q      <= start_d;
         scan_k_q     <= scan_k_d;
         best_found_q <= best_found_d;
         best_prio_q  <= best_prio_d;
         best_slot_q  <= best_slot_d;
         best_id_q    <= best_id_d;
         slice_q      <= slice_d;
         op_q         <= op_d;
      end
   end

`ifdef TASK_DISPATCH_STATS_EN
   logic [15:0] dispatch_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         dispatch_q <= 16'h0000;
      end else if (state_q == ST_ISSUE) begin
         dispatch_q <= dispatch_q + 16'd1;
      end
   end

   assign dispatch_count = dispatch_q;
`endif

   // Status outputs decode straight from the state register.
   assign host_ready = (state_q == ST_IDLE);
   assign busy       = (state_q != ST_IDLE);
   assign cur_valid  = (state_q == ST_ISSUE) || (state_q == ST_RUN) || (state_q == ST_FINISH);
   assign cur_id     = cur_valid ? best_id_q : 4'h0;
   assign op_out     = op_q;

endmodule
